enc4to2_queue: RTL and testbench
================================

# enc4to2_queue

Sequential 4-to-2 encoder: the request-side counterpart of the 2-to-4 enable decoder. It captures one-hot or multi-hot request lines, queues every asserted line as a pending bit, and emits one 2-bit index per handshake on a valid/ready output. Sits between request sources (or a decoder's output bus being looped back) and any consumer that wants serialized indices.

## Interface
- `PRIO_LOW_FIRST`, default 1: fixed-priority order. 1 means index 0 is highest; 0 means index 3 is highest. Ignored when round-robin is compiled in.
- `clk`  input  1  rising-edge clock, sole clock domain.
- `rst_n`  input  1  asynchronous, active-low reset.
- `EN`  input  1  request capture enable; when 0, `in` is ignored but queued requests still drain.
- `in`  input  4  request lines, level-sampled each cycle.
- `out`  output  2  encoded index of the granted request (registered).
- `valid`  output  1  `out` holds a granted index (registered).
- `ready`  input  1  consumer accepts `out` on a cycle where `valid && ready`.
- `pending`  output  4  queued, not-yet-granted requests (registered).
- `overflow`  output  1  one-cycle pulse: a request arrived on a line already pending (registered).

## Operation
- Eligible set, combinational: `elig = pending | (EN ? in : 4'b0)`.
- Load condition: `!valid || ready`.
- On a clock edge where the load condition holds:
  - if `elig != 0`: `out <= index(grant)`, `valid <= 1`, `pending <= elig & ~grant`;
  - else `valid <= 0`, `pending <= 0`, and `out` holds its value.
- On a clock edge where the load condition does not hold (stall):
  - `pending <= elig`;
  - `out` and `valid` hold.
- `grant` is the one-hot selection of one bit of `elig` by the priority rule (see Configuration).
- `overflow <= EN && |(in & pending)`. The currently held `out` index is not counted as pending, so re-requesting it is queued, not an overflow. Duplicate requests merge; nothing is counted.
- Arrivals and a grant on the same edge: the new arrival's bit is set in `pending` unless that same bit is the one granted this edge. A granted bit that is still present on `in` next cycle is re-queued. Level-held requests therefore repeat once per accept.
- No FIFO ordering across lines; only the priority rule decides.

## Timing
- Reset values: `out = 2'b00`, `valid = 0`, `pending = 4'b0000`, `overflow = 0`, round-robin pointer = 3 (so index 0 is first after reset).
- Reset takes effect asynchronously; release is synchronous to `clk`. Reset mid-stall discards `pending` and the held `out`.
- Latency:
  - `in` asserted before edge k with the output idle: `valid` and `out` are updated after edge k (1 cycle).
  - Back-to-back throughput: one index per cycle while `ready = 1`.
- `out` stays stable while `valid && !ready`. `valid` never drops without an accept.
- `overflow` is high for exactly the cycle after the offending edge.

## Configuration
- `ENC_ROUND_ROBIN_EN` defined: rotating priority. The search starts at `(last_granted + 1) mod 4` and wraps 3→0. The pointer updates only on edges that load a grant. `PRIO_LOW_FIRST` is unused.
- `ENC_ROUND_ROBIN_EN` undefined: fixed priority per `PRIO_LOW_FIRST`. No pointer register is built.

## Test plan
- Reset, then `EN=1`, `in=4'b0100` for one cycle, `ready=1` → next cycle `valid=1`, `out=2'b10`; following cycle `valid=0`, `pending=0`.
- `EN=1`, `in=4'b1011` for one cycle, `ready=1`, fixed priority, `PRIO_LOW_FIRST=1` → `out` sequence 00, 01, 11 on consecutive cycles, then `valid=0`.
- `ready=0` with `in=4'b0011` for one cycle → `out=00` held, `pending=4'b0010`. Then `in=4'b0010` again → `overflow` pulses 1 cycle. Raise `ready` → 01 emitted once.
- `EN=0` with `in=4'b1111` → no `valid`, `pending` stays 0. `EN=0` mid-drain with `pending=4'b1000` → `out=11` still emitted.
- With `ENC_ROUND_ROBIN_EN` defined, hold `in=4'b0101`, `ready=1` → `out` alternates 00, 10, 00, 10.
- Assert `rst_n=0` mid-stall with `pending=4'b0110`, `valid=1` → all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/enc4to2_queue_if.sv
// Request/grant bundle for enc4to2_queue: request capture, encoded output stream and status.
// master is the encoder side; slave is the request source / index consumer side.
interface enc4to2_queue_if;
   logic       EN;
   logic [3:0] in;
   logic [1:0] out;
   logic       valid;
   logic       ready;
   logic [3:0] pending;
   logic       overflow;

   modport master (
      input  EN,
      input  in,
      input  ready,
      output out,
      output valid,
      output pending,
      output overflow
   );

   modport slave (
      output EN,
      output in,
      output ready,
      input  out,
      input  valid,
      input  pending,
      input  overflow
   );
endinterface

// File: rtl/enc4to2_queue.sv
// Sequential 4-to-2 encoder: queues asserted request lines and emits one index per accept.
// Define ENC_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority per PRIO_LOW_FIRST.
module enc4to2_queue #(
   parameter int unsigned PRIO_LOW_FIRST = 1
) (
   input logic             clk,
   input logic             rst_n,
   enc4to2_queue_if.master bus
);
   logic [3:0] pending_q, pending_d;
   logic [1:0] out_q, out_d;
   logic       valid_q, valid_d;
   logic       overflow_q, overflow_d;
   logic [3:0] elig, grant;
   logic [1:0] grant_idx;
   logic       load;

   assign elig = pending_q | (bus.EN ? bus.in : 4'b0000);
   assign load = !valid_q || bus.ready;

`ifdef ENC_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d;

   // Walk offsets 4..1 from the pointer; the last hit is the nearest after last_granted.
   always_comb begin
      grant_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (elig[ptr_q + 2'(i + 1)]) grant_idx = ptr_q + 2'(i + 1);
      end
   end

   assign ptr_d = (load && (|elig)) ? grant_idx : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 2'd3;
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      grant_idx = 2'd0;
      if (PRIO_LOW_FIRST != 0) begin
         for (int i = 3; i >= 0; i--) begin
            if (elig[i]) grant_idx = 2'(i);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (elig[i]) grant_idx = 2'(i);
         end
      end
   end
`endif

   assign grant = 4'b0001 << grant_idx;

   always_comb begin
      out_d     = out_q;
      valid_d   = valid_q;
      pending_d = elig;
      if (load) begin
         if (|elig) begin
            out_d     = grant_idx;
            valid_d   = 1'b1;
            pending_d = elig & ~grant;
         end else begin
            valid_d   = 1'b0;
            pending_d = 4'b0000;
         end
      end
   end

   // The held out index is not in pending, so re-requesting it is not an overflow.
   assign overflow_d = bus.EN && (|(bus.in & pending_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= 2'b00;
         valid_q    <= 1'b0;
         pending_q  <= 4'b0000;
         overflow_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         valid_q    <= valid_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.out      = out_q;
   assign bus.valid    = valid_q;
   assign bus.pending  = pending_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_enc4to2_queue.sv
// Scoreboard bench for enc4to2_queue: directed requests push expected indices, a negedge
// monitor pops and compares on every accepted output.
module tb_enc4to2_queue;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   sbq[$];

   enc4to2_queue_if bus();

   enc4to2_queue #(
      .PRIO_LOW_FIRST(1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      bus.EN = 1'b0;
      bus.in = 4'b0000;
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: every accepted output must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.valid && bus.ready) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %0d expected none at %0t", bus.out, $time);
         end else begin
            int exp_idx;
            exp_idx = sbq.pop_front();
            if (int'(bus.out) != exp_idx) begin
               errors++;
               $display("FAIL out_seq: got %0d expected %0d at %0t", bus.out, exp_idx, $time);
            end
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.EN    = 1'b0;
      bus.in    = 4'b0000;
      bus.ready = 1'b1;
      #12;
      chk("rst_out", int'(bus.out), 0);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_pending", int'(bus.pending), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      rst_n = 1'b1;
      step();

      // Single one-hot request.
      bus.EN = 1'b1;
      bus.in = 4'b0100;
      sbq.push_back(2);
      step();
      bus.in = 4'b0000;
      chk("t1_valid", int'(bus.valid), 1);
      step();
      chk("t1_idle_valid", int'(bus.valid), 0);
      chk("t1_idle_pending", int'(bus.pending), 0);

      // Multi-hot burst drains in priority order.
`ifdef ENC_ROUND_ROBIN_EN
      sbq.push_back(3); sbq.push_back(0); sbq.push_back(1);
`else
      sbq.push_back(0); sbq.push_back(1); sbq.push_back(3);
`endif
      bus.in = 4'b1011;
      step();
      bus.in = 4'b0000;
      step();
      step();
      step();
      chk("t2_done_valid", int'(bus.valid), 0);

      // Stall, overflow on re-request, then drain.
      bus.ready = 1'b0;
      bus.in    = 4'b0011;
      sbq.push_back(0);
      sbq.push_back(1);
      step();
      bus.in = 4'b0000;
      chk("t3_valid", int'(bus.valid), 1);
      chk("t3_pending", int'(bus.pending), 4'b0010);
      bus.in = 4'b0010;
      step();
      bus.in = 4'b0000;
      chk("t3_overflow", int'(bus.overflow), 1);
      chk("t3_out_held", int'(bus.out), 0);
      chk("t3_pending_merge", int'(bus.pending), 4'b0010);
      step();
      chk("t3_overflow_pulse", int'(bus.overflow), 0);
      bus.ready = 1'b1;
      step();
      step();
      chk("t3_done_valid", int'(bus.valid), 0);
      chk("t3_done_pending", int'(bus.pending), 0);

      // EN low ignores in; EN low mid-drain still empties pending.
      bus.EN = 1'b0;
      bus.in = 4'b1111;
      step();
      step();
      chk("t4_en0_valid", int'(bus.valid), 0);
      chk("t4_en0_pending", int'(bus.pending), 0);
      chk("t4_en0_overflow", int'(bus.overflow), 0);
      bus.EN = 1'b1;
      bus.in = 4'b1001;
`ifdef ENC_ROUND_ROBIN_EN
      sbq.push_back(3); sbq.push_back(0);
`else
      sbq.push_back(0); sbq.push_back(3);
`endif
      step();
      bus.EN = 1'b0;
      bus.in = 4'b1111;
`ifdef ENC_ROUND_ROBIN_EN
      chk("t4_drain_pending", int'(bus.pending), 4'b0001);
`else
      chk("t4_drain_pending", int'(bus.pending), 4'b1000);
`endif
      step();
      step();
      chk("t4_done_valid", int'(bus.valid), 0);
      chk("t4_done_pending", int'(bus.pending), 0);

      // Level-held requests repeat once per accept.
      chk("sb_empty_pre_rst", sbq.size(), 0);
      do_reset();
      bus.EN = 1'b1;
      bus.in = 4'b0101;
`ifdef ENC_ROUND_ROBIN_EN
      sbq.push_back(0); sbq.push_back(2); sbq.push_back(0); sbq.push_back(2); sbq.push_back(0);
`else
      sbq.push_back(0); sbq.push_back(0); sbq.push_back(0); sbq.push_back(0); sbq.push_back(2);
`endif
      step();
      step();
      step();
      step();
      bus.in = 4'b0000;
      step();
      step();
      chk("t5_done_valid", int'(bus.valid), 0);

      // Asynchronous reset in the middle of a stall.
      do_reset();
      bus.EN    = 1'b1;
      bus.ready = 1'b0;
      bus.in    = 4'b0111;
      step();
      bus.in = 4'b0000;
      chk("t6_pending", int'(bus.pending), 4'b0110);
      chk("t6_valid", int'(bus.valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", int'(bus.valid), 0);
      chk("t6_async_pending", int'(bus.pending), 0);
      chk("t6_async_out", int'(bus.out), 0);
      chk("t6_async_overflow", int'(bus.overflow), 0);
      rst_n     = 1'b1;
      bus.ready = 1'b1;
      step();
      step();
      chk("t6_after_valid", int'(bus.valid), 0);
      chk("sb_empty_end", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
